npc_lsu: RTL and testbench

//  Load/store unit between the execute stage and the DPI-C data-memory port (read port 2 + write port).

---
 rtl/npc_pkg.sv | 48 ++++
 rtl/npc_lsu_if.sv | 51 +++++
 rtl/npc_lsu_ext.sv | 45 ++++
 rtl/npc_lsu.sv | 137 +++++++++++++
 tb/tb_npc_lsu.sv | 397 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/npc_pkg.sv
// Shared definitions for the npc load/store path.
// Funct3 codes, LSU state encoding and store byte masks.
package npc_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [7:0] WMASK_B = 8'h01;
  localparam logic [7:0] WMASK_H = 8'h03;
  localparam logic [7:0] WMASK_W = 8'h0F;

  typedef enum logic [1:0] {
    LSU_IDLE,
    LSU_ACCESS,
    LSU_WAIT,
    LSU_RESP
  } lsu_state_t;

  function automatic logic [31:0] size_bytes(
    input logic [1:0] sz
  );
    logic [31:0] n;
    n = 32'd4;
    unique case (1'b1)
      (sz == 2'b00): n = 32'd1;
      (sz == 2'b01): n = 32'd2;
      default:       n = 32'd4;
    endcase
    return n;
  endfunction

  function automatic logic [7:0] wmask_of(
    input logic [1:0] sz
  );
    logic [7:0] m;
    m = WMASK_W;
    unique case (1'b1)
      (sz == 2'b00): m = WMASK_B;
      (sz == 2'b01): m = WMASK_H;
      default:       m = WMASK_W;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/npc_lsu_if.sv
// Request, response and data-memory signals of the LSU.
// slave is the LSU side; master is the execute stage plus memory.
interface npc_lsu_if;

  logic        in_valid;
  logic        in_ready;
  logic        in_ren;
  logic        in_wen;
  logic [2:0]  in_funct3;
  logic [31:0] in_addr;
  logic [31:0] in_wdata;

  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_rdata;
  logic        out_err;

  logic        mem_valid;
  logic [31:0] mem_rlen;
  logic [31:0] mem_raddr;
  logic [31:0] mem_rdata;
  logic        mem_wen;
  logic [31:0] mem_waddr;
  logic [31:0] mem_wdata;
  logic [7:0]  mem_wmask;

  modport slave (
    input  in_valid, in_ren, in_wen,
    input  in_funct3, in_addr, in_wdata,
    output in_ready,
    output out_valid, out_rdata, out_err,
    input  out_ready,
    output mem_valid, mem_rlen, mem_raddr,
    input  mem_rdata,
    output mem_wen, mem_waddr, mem_wdata,
    output mem_wmask
  );

  modport master (
    output in_valid, in_ren, in_wen,
    output in_funct3, in_addr, in_wdata,
    input  in_ready,
    input  out_valid, out_rdata, out_err,
    output out_ready,
    input  mem_valid, mem_rlen, mem_raddr,
    output mem_rdata,
    input  mem_wen, mem_waddr, mem_wdata,
    input  mem_wmask
  );

endinterface

// File: rtl/npc_lsu_ext.sv
// Load-data extender and request legality/alignment checker.
// Purely combinational; checker and extender have separate inputs.
module npc_lsu_ext
  import npc_pkg::*;
(
  input  logic        chk_load,
  input  logic [2:0]  chk_f3,
  input  logic [1:0]  chk_addr,
  output logic        chk_err,
  input  logic [2:0]  ext_f3,
  input  logic [31:0] ext_raw,
  output logic [31:0] ext_data
);

  logic legal;
  logic mis;

  always_comb begin
    legal = (chk_f3 == F3_B)
         || (chk_f3 == F3_H)
         || (chk_f3 == F3_W)
         || (chk_load && (chk_f3 == F3_BU))
         || (chk_load && (chk_f3 == F3_HU));
    mis = ((chk_f3[1:0] == 2'b01) && chk_addr[0])
       || ((chk_f3[1:0] == 2'b10) && (chk_addr != 2'b00));
    chk_err = !legal || mis;
  end

  always_comb begin
    ext_data = ext_raw;
    unique case (1'b1)
      (ext_f3 == F3_B):
        ext_data = {{24{ext_raw[7]}}, ext_raw[7:0]};
      (ext_f3 == F3_BU):
        ext_data = {24'd0, ext_raw[7:0]};
      (ext_f3 == F3_H):
        ext_data = {{16{ext_raw[15]}}, ext_raw[15:0]};
      (ext_f3 == F3_HU):
        ext_data = {16'd0, ext_raw[15:0]};
      default:
        ext_data = ext_raw;
    endcase
  end

endmodule

// File: rtl/npc_lsu.sv
// Non-pipelined load/store unit: one op in flight, fixed-latency
// memory access, extended load data returned through a handshake.
module npc_lsu
  import npc_pkg::*;
#(
  parameter int unsigned LATENCY = 1
) (
  input  logic      clk,
  input  logic      rst,
  npc_lsu_if.slave  bus
);

  localparam bit HAS_WAIT = (LATENCY != 0);
  localparam logic [3:0] CNT_INIT =
    HAS_WAIT ? 4'(LATENCY - 1) : 4'd0;

  lsu_state_t  state;
  lsu_state_t  state_n;
  logic        ld_q;
  logic        st_q;
  logic        err_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic [3:0]  cnt_q;

  logic        accept;
  logic        ld_in;
  logic        st_in;
  logic        chk_err;
  logic [31:0] ext_data;

  assign ld_in  = bus.in_ren;
  assign st_in  = bus.in_wen && !bus.in_ren;
  assign accept = bus.in_valid && bus.in_ready;

  npc_lsu_ext u_ext (
    .chk_load (bus.in_ren),
    .chk_f3   (bus.in_funct3),
    .chk_addr (bus.in_addr[1:0]),
    .chk_err  (chk_err),
    .ext_f3   (f3_q),
    .ext_raw  (bus.mem_rdata),
    .ext_data (ext_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= LSU_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      LSU_IDLE: begin
        if (accept) begin
          if (!(ld_in || st_in)) state_n = LSU_RESP;
          else if (chk_err)      state_n = LSU_RESP;
          else                   state_n = LSU_ACCESS;
        end
      end
      LSU_ACCESS:
        state_n = HAS_WAIT ? LSU_WAIT : LSU_RESP;
      LSU_WAIT:
        if (cnt_q == 4'd0) state_n = LSU_RESP;
      LSU_RESP:
        if (bus.out_ready) state_n = LSU_IDLE;
      default:
        state_n = LSU_IDLE;
    endcase
  end

  // Load data is extended as it is captured, so RESP only holds it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ld_q    <= 1'b0;
      st_q    <= 1'b0;
      err_q   <= 1'b0;
      f3_q    <= 3'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      cnt_q   <= 4'd0;
    end else begin
      if (accept) begin
        ld_q    <= ld_in;
        st_q    <= st_in;
        err_q   <= (ld_in || st_in) && chk_err;
        f3_q    <= bus.in_funct3;
        addr_q  <= bus.in_addr;
        wdata_q <= bus.in_wdata;
        rdata_q <= 32'd0;
      end
      if (state == LSU_ACCESS) begin
        cnt_q <= CNT_INIT;
        if (ld_q) rdata_q <= ext_data;
      end
      if ((state == LSU_WAIT) && (cnt_q != 4'd0))
        cnt_q <= cnt_q - 4'd1;
    end
  end

  always_comb begin
    bus.in_ready  = (state == LSU_IDLE) && !rst;
    bus.out_valid = 1'b0;
    bus.out_rdata = 32'd0;
    bus.out_err   = 1'b0;
    bus.mem_valid = 1'b0;
    bus.mem_rlen  = 32'd0;
    bus.mem_raddr = 32'd0;
    bus.mem_wen   = 1'b0;
    bus.mem_waddr = 32'd0;
    bus.mem_wdata = 32'd0;
    bus.mem_wmask = 8'd0;
    unique case (1'b1)
      (state == LSU_ACCESS) && ld_q: begin
        bus.mem_valid = 1'b1;
        bus.mem_raddr = addr_q;
        bus.mem_rlen  = size_bytes(f3_q[1:0]);
      end
      (state == LSU_ACCESS) && st_q: begin
        bus.mem_wen   = 1'b1;
        bus.mem_waddr = addr_q;
        bus.mem_wdata = wdata_q;
        bus.mem_wmask = wmask_of(f3_q[1:0]);
      end
      (state == LSU_RESP): begin
        bus.out_valid = 1'b1;
        bus.out_rdata = rdata_q;
        bus.out_err   = err_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_npc_lsu.sv
// Bench for npc_lsu: two instances (LATENCY 1 and 0) against a
// byte-array memory model and a size/sign reference computation.
module tb_npc_lsu;
  import npc_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  npc_lsu_if bus();
  npc_lsu_if bus0();

  npc_lsu #(.LATENCY(1)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  npc_lsu #(.LATENCY(0)) u_dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  int tests = 0;
  int fails = 0;
  int sel   = 0;

  logic        t_valid = 1'b0;
  logic        t_ren   = 1'b0;
  logic        t_wen   = 1'b0;
  logic [2:0]  t_f3    = 3'd0;
  logic [31:0] t_addr  = 32'd0;
  logic [31:0] t_wdata = 32'd0;
  logic        t_ordy  = 1'b0;

  assign bus.in_valid   = t_valid && (sel == 0);
  assign bus0.in_valid  = t_valid && (sel == 1);
  assign bus.out_ready  = t_ordy && (sel == 0);
  assign bus0.out_ready = t_ordy && (sel == 1);
  assign bus.in_ren     = t_ren;
  assign bus0.in_ren    = t_ren;
  assign bus.in_wen     = t_wen;
  assign bus0.in_wen    = t_wen;
  assign bus.in_funct3  = t_f3;
  assign bus0.in_funct3 = t_f3;
  assign bus.in_addr    = t_addr;
  assign bus0.in_addr   = t_addr;
  assign bus.in_wdata   = t_wdata;
  assign bus0.in_wdata  = t_wdata;

  logic        o_in_ready;
  logic        o_out_valid;
  logic [31:0] o_out_rdata;
  logic        o_out_err;
  assign o_in_ready  = sel ? bus0.in_ready  : bus.in_ready;
  assign o_out_valid = sel ? bus0.out_valid : bus.out_valid;
  assign o_out_rdata = sel ? bus0.out_rdata : bus.out_rdata;
  assign o_out_err   = sel ? bus0.out_err   : bus.out_err;

  bit [7:0] pmem [int unsigned];
  bit [7:0] rmem [int unsigned];

  function automatic bit [7:0] pget(input int unsigned a);
    return pmem.exists(a) ? pmem[a] : 8'd0;
  endfunction

  function automatic bit [7:0] rget(input int unsigned a);
    return rmem.exists(a) ? rmem[a] : 8'd0;
  endfunction

  // Bytes beyond the requested length are junk on purpose.
  function automatic logic [31:0] prd(
    input logic [31:0] a, input logic [31:0] len
  );
    logic [31:0] r;
    r = $urandom;
    if (a == 32'd0) return 32'd0;
    for (int i = 0; i < 4; i++)
      if (i < len) r[8*i +: 8] = pget(a + i);
    return r;
  endfunction

  int          rd_cnt = 0;
  int          wr_cnt = 0;
  logic [31:0] l_raddr, l_rlen, l_waddr, l_wdata;
  logic [7:0]  l_wmask;

  always @(negedge clk) begin
    bus.mem_rdata  = bus.mem_valid ?
      prd(bus.mem_raddr, bus.mem_rlen) : $urandom;
    bus0.mem_rdata = bus0.mem_valid ?
      prd(bus0.mem_raddr, bus0.mem_rlen) : $urandom;
    if (bus.mem_valid) begin
      rd_cnt++;
      l_raddr = bus.mem_raddr;
      l_rlen  = bus.mem_rlen;
    end
    if (bus0.mem_valid) begin
      rd_cnt++;
      l_raddr = bus0.mem_raddr;
      l_rlen  = bus0.mem_rlen;
    end
    if (bus.mem_wen) begin
      wr_cnt++;
      l_waddr = bus.mem_waddr;
      l_wdata = bus.mem_wdata;
      l_wmask = bus.mem_wmask;
      for (int i = 0; i < 4; i++)
        if (bus.mem_wmask[i])
          pmem[bus.mem_waddr + i] = bus.mem_wdata[8*i +: 8];
    end
    if (bus0.mem_wen) begin
      wr_cnt++;
      l_waddr = bus0.mem_waddr;
      l_wdata = bus0.mem_wdata;
      l_wmask = bus0.mem_wmask;
      for (int i = 0; i < 4; i++)
        if (bus0.mem_wmask[i])
          pmem[bus0.mem_waddr + i] = bus0.mem_wdata[8*i +: 8];
    end
  end

  task automatic preload(input logic [31:0] a, input logic [31:0] v,
                         input int n);
    for (int i = 0; i < n; i++) begin
      pmem[a + i] = v[8*i +: 8];
      rmem[a + i] = v[8*i +: 8];
    end
  endtask

  // Reference: decide legality, size and result from the ISA rules.
  task automatic ref_op(
    input bit ren, input bit wen, input logic [2:0] f,
    input logic [31:0] a, input logic [31:0] wd, input int lat_p,
    output bit ld, output bit st, output bit err,
    output logic [31:0] erd, output int elat, output int nb
  );
    bit     legal;
    longint v;
    ld = ren;
    st = !ren && wen;
    nb = (f[1:0] == 2'd0) ? 1 : (f[1:0] == 2'd1) ? 2 : 4;
    legal = ld ? (f inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})
               : (f inside {3'd0, 3'd1, 3'd2});
    err = (ld || st) && (!legal || ((a % nb) != 0));
    erd = 32'd0;
    if (ld && !err) begin
      v = 0;
      if (a != 32'd0)
        for (int i = 0; i < nb; i++)
          v += longint'(rget(a + i)) << (8 * i);
      if (f < 3'd4 && nb < 4 && v >= (64'd1 << (8 * nb - 1)))
        v -= (64'd1 << (8 * nb));
      erd = v[31:0];
    end
    if (st && !err)
      for (int i = 0; i < nb; i++)
        rmem[a + i] = 8'((wd >> (8 * i)) & 32'hFF);
    elat = ((ld || st) && !err) ? lat_p + 2 : 1;
  endtask

  task automatic run_op(
    input int s, input bit ren, input bit wen, input logic [2:0] f,
    input logic [31:0] a, input logic [31:0] wd, input int hold
  );
    bit ld, st, err, early;
    logic [31:0] erd;
    int elat, nb, n, k, rd0, wr0;
    ref_op(ren, wen, f, a, wd, (s == 1) ? 0 : 1,
           ld, st, err, erd, elat, nb);
    @(negedge clk);
    sel = s; t_ren = ren; t_wen = wen; t_f3 = f;
    t_addr = a; t_wdata = wd; t_valid = 1'b1;
    rd0 = rd_cnt; wr0 = wr_cnt;
    k = 0;
    while (!o_in_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    tests++;
    if (!o_in_ready) begin
      fails++;
      $display("FAIL accept_timeout in_ready=%b want 1", o_in_ready);
      t_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 t_valid = 1'b0;
    n = 0;
    early = 1'b0;
    do begin
      @(negedge clk);
      n++;
      if (o_in_ready) early = 1'b1;
    end while (!o_out_valid && n < 40);
    tests++;
    if (!o_out_valid || n != elat) begin
      fails++;
      $display("FAIL latency got %0d cycles (valid=%b) want %0d",
               n, o_out_valid, elat);
    end
    tests++;
    if (early) begin
      fails++;
      $display("FAIL busy_ready in_ready=1 while busy want 0");
    end
    tests++;
    if (o_out_rdata !== erd) begin
      fails++;
      $display("FAIL rdata a=%h f3=%0d got %h want %h",
               a, f, o_out_rdata, erd);
    end
    tests++;
    if (o_out_err !== err) begin
      fails++;
      $display("FAIL err a=%h f3=%0d got %b want %b",
               a, f, o_out_err, err);
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      tests++;
      if (o_out_valid !== 1'b1 || o_out_rdata !== erd
          || o_out_err !== err || o_in_ready !== 1'b0) begin
        fails++;
        $display("FAIL hold v=%b d=%h r=%b want 1 %h 0",
                 o_out_valid, o_out_rdata, o_in_ready, erd);
      end
    end
    t_ordy = 1'b1;
    @(posedge clk);
    #1 t_ordy = 1'b0;
    @(negedge clk);
    tests++;
    if (o_out_valid !== 1'b0 || o_in_ready !== 1'b1) begin
      fails++;
      $display("FAIL release out_valid=%b in_ready=%b want 0 1",
               o_out_valid, o_in_ready);
    end
    tests++;
    if ((rd_cnt - rd0) != ((ld && !err) ? 1 : 0)) begin
      fails++;
      $display("FAIL read_strobes got %0d want %0d",
               rd_cnt - rd0, (ld && !err) ? 1 : 0);
    end
    tests++;
    if ((wr_cnt - wr0) != ((st && !err) ? 1 : 0)) begin
      fails++;
      $display("FAIL write_strobes got %0d want %0d",
               wr_cnt - wr0, (st && !err) ? 1 : 0);
    end
    if (ld && !err) begin
      tests++;
      if (l_raddr !== a || l_rlen !== 32'(nb)) begin
        fails++;
        $display("FAIL read_port addr=%h len=%0d want %h %0d",
                 l_raddr, l_rlen, a, nb);
      end
    end
    if (st && !err) begin
      tests++;
      if (l_waddr !== a || l_wdata !== wd
          || l_wmask !== 8'((1 << nb) - 1)) begin
        fails++;
        $display("FAIL write_port %h %h %h want %h %h %h",
                 l_waddr, l_wdata, l_wmask, a, wd,
                 8'((1 << nb) - 1));
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    #1;
    tests++;
    if ({bus.in_ready, bus.out_valid, bus.out_err,
         bus.mem_valid, bus.mem_wen, bus0.in_ready,
         bus0.out_valid, bus0.mem_valid, bus0.mem_wen} !== 9'd0
        || bus.out_rdata !== 32'd0 || bus.mem_rlen !== 32'd0
        || bus.mem_raddr !== 32'd0 || bus.mem_waddr !== 32'd0
        || bus.mem_wdata !== 32'd0 || bus.mem_wmask !== 8'd0) begin
      fails++;
      $display("FAIL reset_outputs ready=%b valid=%b rdata=%h want 0",
               bus.in_ready, bus.out_valid, bus.out_rdata);
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    tests++;
    if (bus.in_ready !== 1'b1 || bus0.in_ready !== 1'b1
        || bus.out_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_release in_ready=%b/%b want 1",
               bus.in_ready, bus0.in_ready);
    end
  endtask

  task automatic test_lb;
    preload(32'h8000_0010, 32'h0000_00F0, 1);
    run_op(0, 1'b1, 1'b0, F3_B, 32'h8000_0010, 32'd0, 0);
  endtask

  task automatic test_store_half;
    run_op(0, 1'b0, 1'b1, F3_H, 32'h8000_0022, 32'h1234_ABCD, 0);
    run_op(0, 1'b1, 1'b0, F3_HU, 32'h8000_0022, 32'd0, 0);
    run_op(0, 1'b1, 1'b0, F3_H, 32'h8000_0022, 32'd0, 0);
  endtask

  task automatic test_errors;
    run_op(0, 1'b1, 1'b0, F3_W, 32'h8000_0006, 32'd0, 0);
    run_op(0, 1'b0, 1'b1, F3_H, 32'h8000_0021, 32'h55, 0);
    run_op(0, 1'b0, 1'b1, F3_BU, 32'h8000_0020, 32'h55, 0);
    run_op(1, 1'b1, 1'b0, 3'b011, 32'h8000_0020, 32'd0, 0);
    run_op(1, 1'b0, 1'b0, F3_W, 32'h8000_0020, 32'd0, 0);
  endtask

  task automatic test_hold;
    preload(32'h8000_0030, 32'h0000_FFFE, 4);
    run_op(0, 1'b1, 1'b0, F3_HU, 32'h8000_0030, 32'd0, 5);
  endtask

  task automatic test_reset_mid;
    int rd0;
    preload(32'h8000_0040, 32'h8765_4321, 4);
    @(negedge clk);
    sel = 0; t_ren = 1'b1; t_wen = 1'b0; t_f3 = F3_W;
    t_addr = 32'h8000_0040; t_valid = 1'b1;
    @(posedge clk);
    #1 t_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    tests++;
    if ({bus.in_ready, bus.out_valid, bus.out_err,
         bus.mem_valid, bus.mem_wen} !== 5'd0
        || bus.out_rdata !== 32'd0
        || bus.mem_raddr !== 32'd0) begin
      fails++;
      $display("FAIL reset_mid valid=%b ready=%b rdata=%h want 0",
               bus.out_valid, bus.in_ready, bus.out_rdata);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    rd0 = rd_cnt;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      tests++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1
          || rd_cnt != rd0) begin
        fails++;
        $display("FAIL reset_drop valid=%b ready=%b want 0 1",
                 bus.out_valid, bus.in_ready);
      end
    end
    run_op(0, 1'b1, 1'b0, F3_W, 32'h8000_0040, 32'd0, 0);
  endtask

  task automatic test_back_to_back;
    logic [31:0] w;
    w = $urandom;
    run_op(1, 1'b0, 1'b1, F3_W, 32'h8000_0050, w, 0);
    run_op(1, 1'b1, 1'b0, F3_W, 32'h8000_0050, 32'd0, 0);
    run_op(1, 1'b1, 1'b0, F3_B, 32'h8000_0053, 32'd0, 0);
  endtask

  task automatic test_addr_zero;
    preload(32'd0, 32'hDEAD_BEEF, 4);
    run_op(0, 1'b1, 1'b0, F3_W, 32'd0, 32'd0, 0);
  endtask

  task automatic test_random;
    logic [31:0] a;
    for (int i = 0; i < 64; i += 4)
      preload(32'h8000_0000 + i, $urandom, 4);
    for (int i = 0; i < 60; i++) begin
      a = ($urandom_range(0, 7) == 0) ? 32'd0
        : 32'h8000_0000 + $urandom_range(0, 63);
      run_op($urandom_range(0, 1), 1'($urandom), 1'($urandom),
             3'($urandom), a, $urandom, $urandom_range(0, 2));
    end
  endtask

  initial begin
    test_reset();
    test_lb();
    test_store_half();
    test_errors();
    test_hold();
    test_reset_mid();
    test_back_to_back();
    test_addr_zero();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
